// File: rtl/dsp_bb_pkg.sv
// rtl/dsp_bb_pkg.sv - shared slot-state type and width helpers for the adder scheduler
package dsp_bb_pkg;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

   function automatic int max(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

endpackage

// File: rtl/adder_sched_arbiter.sv
// rtl/adder_sched_arbiter.sv - single-grant arbiter; ADDER_SCHED_RR_EN selects round-robin, else fixed priority
module adder_sched_arbiter
   import dsp_bb_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IDW  = max(1, clog2(NREQ))
) (
   input  logic [NREQ-1:0] valid,
   input  logic            enable,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  index
);

   logic [IDW-1:0] base;
   logic [IDW-1:0] cand;
   logic           found;
   int             cand_i;

`ifdef ADDER_SCHED_RR_EN
   assign base = ptr;
`else
   logic [IDW-1:0] unused_ptr;
   assign unused_ptr = ptr;
   assign base       = '0;
`endif

   // Scan from base upward with wrap; the first valid index found wins.
   always_comb begin
      grant  = '0;
      index  = '0;
      found  = 1'b0;
      cand_i = 0;
      cand   = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand_i = int'(base) + k;
         if (cand_i >= NREQ) begin
            cand_i = cand_i - NREQ;
         end
         cand = cand_i[IDW-1:0];
         if (!found && valid[cand]) begin
            found       = 1'b1;
            index       = cand;
            grant[cand] = enable;
         end
      end
   end

endmodule

// File: rtl/unsigned_adder.sv
// rtl/unsigned_adder.sv - combinational unsigned adder, result two bits wider than the wider operand
module unsigned_adder
   import dsp_bb_pkg::*;
#(
   parameter  int AWIDTH = 16,
   parameter  int BWIDTH = 16,
   localparam int OWIDTH = max(AWIDTH, BWIDTH) + 2
) (
   input  logic [AWIDTH-1:0] a,
   input  logic [BWIDTH-1:0] b,
   output logic [OWIDTH-1:0] sum
);

   assign sum = OWIDTH'(a) + OWIDTH'(b);

endmodule

// File: rtl/unsigned_adder_sched.sv
// rtl/unsigned_adder_sched.sv - one shared adder serving NREQ requesters; ADDER_SCHED_RR_EN enables round-robin
module unsigned_adder_sched
   import dsp_bb_pkg::*;
#(
   parameter  int NREQ   = 4,
   parameter  int AWIDTH = 16,
   parameter  int BWIDTH = 16,
   localparam int SWIDTH = max(AWIDTH, BWIDTH) + 1,
   localparam int IDW    = max(1, clog2(NREQ))
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [NREQ-1:0]        i_req_valid,
   output logic [NREQ-1:0]        o_req_ready,
   input  logic [NREQ*AWIDTH-1:0] i_req_a,
   input  logic [NREQ*BWIDTH-1:0] i_req_b,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [SWIDTH-1:0]      o_sum,
   output logic [IDW-1:0]         o_id
);

   slot_state_t       state_q;
   slot_state_t       state_d;
   logic              slot_free;
   logic              accept;
   logic [NREQ-1:0]   grant;
   logic [IDW-1:0]    gidx;
   logic [IDW-1:0]    ptr_q;
   logic [AWIDTH-1:0] sel_a;
   logic [BWIDTH-1:0] sel_b;
   logic [SWIDTH:0]   sum_full;
   logic              unused_sum_msb;
   logic [SWIDTH-1:0] sum_q;
   logic [IDW-1:0]    id_q;

   assign slot_free = (state_q == SLOT_EMPTY) || i_ready;

   adder_sched_arbiter #(
      .NREQ(NREQ)
   ) u_arb (
      .valid (i_req_valid),
      .enable(slot_free && !i_reset),
      .ptr   (ptr_q),
      .grant (grant),
      .index (gidx)
   );

   assign o_req_ready = grant;
   assign accept      = |grant;

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int r = 0; r < NREQ; r++) begin
         if (gidx == IDW'(r)) begin
            sel_a = i_req_a[r*AWIDTH +: AWIDTH];
            sel_b = i_req_b[r*BWIDTH +: BWIDTH];
         end
      end
   end

   unsigned_adder #(
      .AWIDTH(AWIDTH),
      .BWIDTH(BWIDTH)
   ) u_add (
      .a  (sel_a),
      .b  (sel_b),
      .sum(sum_full)
   );

   // Operands fit in SWIDTH-1 bits, so the adder's top bit is always zero.
   assign unused_sum_msb = sum_full[SWIDTH];

   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = SLOT_FULL;
      end else if (i_ready) begin
         state_d = SLOT_EMPTY;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= SLOT_EMPTY;
         sum_q   <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            sum_q <= sum_full[SWIDTH-1:0];
            id_q  <= gidx;
         end
      end
   end

`ifdef ADDER_SCHED_RR_EN
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         ptr_q <= '0;
      end else if (accept) begin
         ptr_q <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      end
   end
`else
   assign ptr_q = '0;
`endif

   assign o_valid = (state_q == SLOT_FULL);
   assign o_sum   = sum_q;
   assign o_id    = id_q;

endmodule
